// File: rtl/updown_pkg.sv
// Shared types and defaults for the parametrised up/down counter.
package updown_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/updown_next_val.sv
// Combinational next-state for the up/down counter: load clamp, step,
// boundary detection and direction capture. No state is held here.
module updown_next_val
    import updown_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] max_val_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             sat_mode_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o,
    output logic             dir_o
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    mode_e mode_s;
    assign mode_s = mode_e'(sat_mode_i);

    // Select next count, boundary flag and direction by load > enable > hold.
    always_comb begin
        count_o = count_i;
        wrap_o  = 1'b0;
        dir_o   = dir_i;
        if (load_i) begin
            count_o = (load_val_i > max_val_i) ? max_val_i : load_val_i;
        end else if (en_i) begin
            dir_o = up_i;
            // A count stranded above a lowered bound is pulled back in regardless of mode.
            if (count_i > max_val_i) begin
                wrap_o  = 1'b1;
                count_o = up_i ? ZERO : max_val_i;
            end else if (up_i) begin
                if (count_i == max_val_i) begin
                    wrap_o = 1'b1;
                    case (mode_s)
                        MODE_WRAP: count_o = ZERO;
                        MODE_SAT:  count_o = count_i;
                        default:   count_o = count_i;
                    endcase
                end else begin
                    count_o = count_i + ONE;
                end
            end else begin
                if (count_i == ZERO) begin
                    wrap_o = 1'b1;
                    case (mode_s)
                        MODE_WRAP: count_o = max_val_i;
                        MODE_SAT:  count_o = count_i;
                        default:   count_o = count_i;
                    endcase
                end else begin
                    count_o = count_i - ONE;
                end
            end
        end else begin
            count_o = count_i;
        end
    end

endmodule

// File: rtl/updown_counter_ctrl.sv
// Parametrised up/down counter with programmable bound, wrap/saturate mode,
// synchronous load and terminal-count / boundary flags.
module updown_counter_ctrl
    import updown_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap_pulse,
    output logic             dir_q
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             last_dir_q, last_dir_d;

    updown_next_val #(
        .WIDTH(WIDTH)
    ) u_next (
        .count_i   (count_q),
        .max_val_i (max_val),
        .load_val_i(load_val),
        .load_i    (load),
        .en_i      (en),
        .up_i      (up),
        .sat_mode_i(sat_mode),
        .dir_i     (last_dir_q),
        .count_o   (count_d),
        .wrap_o    (wrap_d),
        .dir_o     (last_dir_d)
    );

    // State registers; reset acts asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= RESET_VAL;
            wrap_q     <= 1'b0;
            last_dir_q <= 1'b1;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            last_dir_q <= last_dir_d;
        end
    end

    assign count      = count_q;
    assign wrap_pulse = wrap_q;
    assign dir_q      = last_dir_q;
    // Terminal count tracks the live direction so it is valid straight out of reset.
    assign tc         = up ? (count_q == max_val) : (count_q == {WIDTH{1'b0}});

endmodule
